// File: rtl/extnet_frame_sched.sv
// Frame scheduler: free-running raster for the extnet datapath, pulls RGB pixels in the active area of each issued frame.
// Latency: dp_* registered 1 cycle after the raster; src_ready ignores src_valid (a missing pixel becomes zero, sticky underrun).
module extnet_frame_sched #(
    parameter int HEIGHT    = 480,
    parameter int WIDTH     = 640,
    parameter int W_HEIGHT  = 525,
    parameter int W_WIDTH   = 800,
    parameter int UINT_BITW = 8,
    parameter int FCNT_BITW = 8
) (
    input  logic                         clock,
    input  logic                         n_rst,
    input  logic                         start,
    input  logic [FCNT_BITW-1:0]         num_frames,
    input  logic [UINT_BITW*3-1:0]       src_pixel,
    input  logic                         src_valid,
    output logic                         src_ready,
    output logic [UINT_BITW*3-1:0]       dp_y,
    output logic [$clog2(W_HEIGHT)-1:0]  dp_vcnt,
    output logic [$clog2(W_WIDTH)-1:0]   dp_hcnt,
    input  logic [$clog2(W_HEIGHT)-1:0]  dp_out_vcnt,
    input  logic [$clog2(W_WIDTH)-1:0]   dp_out_hcnt,
    output logic                         busy,
    output logic                         frame_done,
    output logic [FCNT_BITW-1:0]         frames_done,
    output logic                         underrun
);
    localparam int VW = $clog2(W_HEIGHT);
    localparam int HW = $clog2(W_WIDTH);
    localparam logic [VW-1:0] V_LAST  = VW'(W_HEIGHT - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(W_WIDTH - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(HEIGHT);
    localparam logic [HW-1:0] H_ACT   = HW'(WIDTH);
    localparam logic [VW-1:0] V_OLAST = VW'(HEIGHT - 1);
    localparam logic [HW-1:0] H_OLAST = HW'(WIDTH - 1);
    localparam logic [VW-1:0] V_ONE   = VW'(1);
    localparam logic [HW-1:0] H_ONE   = HW'(1);
    localparam logic [FCNT_BITW-1:0] F_ONE = FCNT_BITW'(1);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [VW-1:0]          cur_v;
    logic [HW-1:0]          cur_h;
    logic                   last;
    logic                   act;
    logic                   start_acc;
    logic                   frame_start;
    logic [FCNT_BITW-1:0]   remaining;
    logic [FCNT_BITW-1:0]   pending;
    logic                   out_act;

    assign last        = (cur_v == V_LAST) && (cur_h == H_LAST);
    assign act         = (cur_v < V_ACT) && (cur_h < H_ACT);
    assign start_acc   = (state == IDLE) && start;
    assign frame_start = (state == RUN) && (cur_v == '0) && (cur_h == '0);
    assign src_ready   = (state == RUN) && act;
    assign frame_done  = out_act && (dp_out_vcnt == V_OLAST) && (dp_out_hcnt == H_OLAST);
    assign busy        = (state != IDLE) || (pending != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARMED;
            ARMED:   if (last) state_nxt = RUN;
            RUN:     if (last && (remaining == F_ONE)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // The raster never stalls: the datapath has no enable.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            cur_v <= '0;
            cur_h <= '0;
        end else if (cur_h == H_LAST) begin
            cur_h <= '0;
            cur_v <= (cur_v == V_LAST) ? '0 : cur_v + V_ONE;
        end else begin
            cur_h <= cur_h + H_ONE;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            remaining <= '0;
        end else if (start_acc) begin
            remaining <= (num_frames == '0) ? F_ONE : num_frames;
        end else if ((state == RUN) && last) begin
            remaining <= remaining - F_ONE;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            dp_vcnt  <= '0;
            dp_hcnt  <= '0;
            dp_y     <= '0;
            underrun <= 1'b0;
        end else begin
            dp_vcnt <= cur_v;
            dp_hcnt <= cur_h;
            dp_y    <= (src_ready && src_valid) ? src_pixel : '0;
            if (start_acc)                   underrun <= 1'b0;
            else if (src_ready && !src_valid) underrun <= 1'b1;
        end
    end

    // Output-side tracking: only datapath frames that were fed by a RUN frame are reported.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            pending     <= '0;
            out_act     <= 1'b0;
            frames_done <= '0;
        end else begin
            case ({frame_start, frame_done})
                2'b10:   pending <= pending + F_ONE;
                2'b01:   pending <= pending - F_ONE;
                default: pending <= pending;
            endcase
            if (frame_done)
                out_act <= 1'b0;
            else if ((dp_out_vcnt == '0) && (dp_out_hcnt == '0) && (pending > FCNT_BITW'(out_act)))
                out_act <= 1'b1;
            if (start_acc)
                frames_done <= '0;
            else if (frame_done && (frames_done != '1))
                frames_done <= frames_done + F_ONE;
        end
    end
endmodule

// File: tb/tb_extnet_frame_sched.sv
// Randomized bench for extnet_frame_sched on a 4x4 active / 6x6 window raster with a 10-cycle stub datapath.
module tb_extnet_frame_sched;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int WH = 6;
    localparam int WW = 6;
    localparam int FR = WH * WW;
    localparam int LASTPIX = (H - 1) * WW + (W - 1);
    localparam int DLY = 10;

    logic        clock = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_frames = '0;
    logic [23:0] src_pixel = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [23:0] dp_y;
    logic [2:0]  dp_vcnt, dp_hcnt;
    logic [2:0]  dp_out_vcnt, dp_out_hcnt;
    logic        busy, frame_done, underrun;
    logic [7:0]  frames_done;

    extnet_frame_sched #(
        .HEIGHT(H), .WIDTH(W), .W_HEIGHT(WH), .W_WIDTH(WW), .UINT_BITW(8), .FCNT_BITW(8)
    ) dut (
        .clock(clock), .n_rst(n_rst), .start(start), .num_frames(num_frames),
        .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
        .dp_y(dp_y), .dp_vcnt(dp_vcnt), .dp_hcnt(dp_hcnt),
        .dp_out_vcnt(dp_out_vcnt), .dp_out_hcnt(dp_out_hcnt),
        .busy(busy), .frame_done(frame_done), .frames_done(frames_done), .underrun(underrun)
    );

    always #5 clock = ~clock;

    // Stub datapath: pure coordinate delay line.
    logic [2:0] dv [DLY];
    logic [2:0] dh [DLY];
    always @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DLY; i++) begin
                dv[i] <= '0;
                dh[i] <= '0;
            end
        end else begin
            dv[0] <= dp_vcnt;
            dh[0] <= dp_hcnt;
            for (int i = 1; i < DLY; i++) begin
                dv[i] <= dv[i-1];
                dh[i] <= dh[i-1];
            end
        end
    end
    assign dp_out_vcnt = dv[DLY-1];
    assign dp_out_hcnt = dh[DLY-1];

    int cyc;
    always @(posedge clock or negedge n_rst) begin
        if (!n_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [23:0] y;
        logic [2:0]  v;
        logic [2:0]  h;
        logic        u;
    } exp_t;
    exp_t q[$];

    int ncmp = 0;
    int nerr = 0;
    bit has_run = 0;
    int ts = 0;
    int f0 = 0;
    int nfr = 0;
    bit under_m = 0;
    bit stop = 0;
    int exp_fd = 0;

    // Reference model in absolute cycles since reset release.
    function automatic bit run_at(input int c);
        return has_run && (c >= f0) && (c < f0 + FR * nfr);
    endfunction
    function automatic bit act_at(input int c);
        return ((c % FR) / WW < H) && ((c % FR) % WW < W);
    endfunction
    function automatic bit idle_at(input int c);
        return !has_run || (c >= f0 + FR * nfr);
    endfunction
    function automatic bit busy_at(input int c);
        return has_run && (c > ts) && (c < f0 + FR * nfr);
    endfunction
    function automatic bit fd_at(input int c);
        if (c < DLY + 1) return 1'b0;
        return run_at(c - DLY - 1) && ((c - DLY - 1) % FR == LASTPIX);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit want, input logic [7:0] nf, input int vp, input bit spur);
        int c;
        bit r, vl;
        logic [23:0] px;
        exp_t e;
        @(negedge clock);
        c = cyc;
        r = run_at(c) && act_at(c);
        chk("src_ready", 32'(src_ready), 32'(r));
        vl = ($urandom_range(0, 99) < vp);
        px = 24'($urandom);
        start = want;
        num_frames = nf;
        if (!want && spur && !idle_at(c) && ($urandom_range(0, 9) == 0)) begin
            start = 1'b1;
            num_frames = 8'($urandom_range(0, 3));
        end
        src_valid = vl;
        src_pixel = px;
        if (want && idle_at(c)) begin
            has_run = 1;
            ts = c;
            f0 = FR * ((c + 1) / FR) + FR;
            nfr = (nf == 0) ? 1 : int'(nf);
            under_m = 0;
        end else if (r && !vl) begin
            under_m = 1;
        end
        e.y = (r && vl) ? px : 24'd0;
        e.v = 3'((c % FR) / WW);
        e.h = 3'((c % FR) % WW);
        e.u = under_m;
        q.push_back(e);
    endtask

    task automatic do_run(input logic [7:0] nf, input int vp);
        int end_c;
        repeat ($urandom_range(0, 40)) step(1'b0, 8'd0, vp, 1'b0);
        step(1'b1, nf, vp, 1'b0);
        end_c = f0 + FR * nfr + 16;
        while (cyc < end_c) step(1'b0, 8'd0, vp, 1'b1);
    endtask

    task automatic reset_checks();
        chk("rst_dp_y", 32'(dp_y), 0);
        chk("rst_dp_vcnt", 32'(dp_vcnt), 0);
        chk("rst_dp_hcnt", 32'(dp_hcnt), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frames_done", 32'(frames_done), 0);
        chk("rst_underrun", 32'(underrun), 0);
    endtask

    // Monitor: pops one expected datapath word per cycle and checks completion tracking.
    initial begin
        int c;
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!n_rst) begin
                exp_fd = 0;
            end else if (!stop) begin
                c = cyc;
                if (q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL scoreboard_empty at cycle %0d: got no entry required one", c);
                end else begin
                    e = q.pop_front();
                    chk("dp_y", 32'(dp_y), 32'(e.y));
                    chk("dp_vcnt", 32'(dp_vcnt), 32'(e.v));
                    chk("dp_hcnt", 32'(dp_hcnt), 32'(e.h));
                    chk("underrun", 32'(underrun), 32'(e.u));
                end
                if (fd_at(c - 1) && exp_fd < 255) exp_fd++;
                if (has_run && ts == c - 1) exp_fd = 0;
                chk("frame_done", 32'(frame_done), 32'(fd_at(c)));
                chk("frames_done", 32'(frames_done), 32'(exp_fd));
                chk("busy", 32'(busy), 32'(busy_at(c)));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #3;
        reset_checks();
        @(posedge clock);
        #2;
        n_rst = 1'b1;

        do_run(8'd1, 100);
        do_run(8'd1, 70);
        do_run(8'd1, 100);
        do_run(8'd3, 90);
        do_run(8'd0, 100);
        do_run(8'd2, 60);

        // Reset in the middle of a RUN frame.
        step(1'b1, 8'd2, 100, 1'b0);
        while (cyc < f0 + 40) step(1'b0, 8'd0, 100, 1'b1);
        @(posedge clock);
        #3;
        n_rst = 1'b0;
        start = 1'b0;
        src_valid = 1'b0;
        #1;
        reset_checks();
        q.delete();
        has_run = 0;
        under_m = 0;
        repeat (2) @(posedge clock);
        #2;
        n_rst = 1'b1;

        do_run(8'd1, 50);
        do_run(8'd2, 100);

        @(posedge clock);
        #3;
        stop = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
